conv_out_frame_collector: RTL
=============================

Name: conv_out_frame_collector

Overview:
- Receiver for the serial conv-layer output stream (valid/pixel pairs, one word per cycle at most, no back-pressure).
- De-serialises the channel-interleaved stream into a planar feature-map write port into a two-bank (ping-pong) frame buffer.
- Signals frame completion to the downstream consumer, which releases banks when done.
- Sits between the conv layer output alignment stage and the next layer's frame memory.

Parameters:
- DATA_WIDTH, 32, pixel word width.
- IMAGE_WIDTH, 32, output feature-map width.
- IMAGE_HEIGHT, 32, output feature-map height.
- CHANNEL_NUM_OUT, 128, channels per output pixel.
- IMAGE_SIZE, IMAGE_WIDTH*IMAGE_HEIGHT, pixels per channel plane (derived).
- BANK_DEPTH, IMAGE_SIZE*CHANNEL_NUM_OUT, words per bank (derived).
- ADDR_WIDTH, $clog2(2*BANK_DEPTH), write address width (18 at defaults; derived).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- valid_in  in  1  input word strobe.
- pxl_in  in  DATA_WIDTH  input word.
- bank_release  in  1  one-cycle pulse: consumer finished the oldest full bank.
- wr_en  out  1  buffer write strobe.
- wr_addr  out  ADDR_WIDTH  buffer write address.
- wr_data  out  DATA_WIDTH  buffer write data.
- frame_done  out  1  one-cycle pulse on the last word of a frame.
- frame_bank  out  1  bank just completed; valid with frame_done.
- bank_full  out  2  per-bank full flags.
- overrun  out  1  sticky flag: a word was dropped.

Behaviour:
- Reset (synchronous, active-high, clock clk) clears all outputs to 0.
- Reset clears wr_bank=0, rd_bank=0, ch_cnt=0, pix_cnt=0, and all bank state. A partial frame at reset is discarded.
- Input order: pixel-major, row-major. For each pixel, CHANNEL_NUM_OUT consecutive words, channel 0 first.
- A word is accepted when valid_in=1 and the effective bank_full[wr_bank]=0.
- Accepted word, next cycle (1-cycle latency, all outputs registered):
  - wr_en=1, wr_data=pxl_in.
  - wr_addr = wr_bank*BANK_DEPTH + ch_cnt*IMAGE_SIZE + pix_cnt.
- Counter rules:
  - ch_cnt increments per accepted word and wraps at CHANNEL_NUM_OUT-1.
  - On ch_cnt wrap, pix_cnt increments.
  - At ch_cnt=CHANNEL_NUM_OUT-1 and pix_cnt=IMAGE_SIZE-1 (last word), both counters go to 0 and wr_bank toggles.
  - In the same output cycle as the last wr_en: frame_done=1, frame_bank=old wr_bank, bank_full[old wr_bank]=1.
- valid_in=0: counters hold, wr_en=0. Gaps of any length are legal.
- Dropped word (valid_in=1 while bank_full[wr_bank]=1): wr_en=0, counters hold, overrun<=1. overrun stays set until reset.
- bank_release:
  - If bank_full[rd_bank]=1: clear it and toggle rd_bank.
  - If bank_full[rd_bank]=0: ignore; no state change.
- Release forwarding: a release clearing the bank that wr_bank points to makes that bank free in the same cycle, so a coincident valid_in word is accepted, not dropped.
- Per-bank state: FREE -> FILLING (first accepted word) -> FULL (last word) -> FREE (release). At most one bank is FILLING.
- wr_addr never exceeds 2*BANK_DEPTH-1. wr_data is don't-care when wr_en=0 but is held stable.

Optional Feature:
- Macro: CONV_OUT_CHECKSUM_EN.
- Defined:
  - Adds output frame_checksum (DATA_WIDTH): XOR of all accepted words of the frame.
  - Latched in the same cycle frame_done=1.
  - Running accumulator clears at frame start and on reset; reset value 0.
- Undefined: port and accumulator absent. All other behaviour identical.

Decomposition:
- Shared header/package conv_collect_pkg:
  - bank state encoding FREE=2'd0, FILLING=2'd1, FULL=2'd2.
  - derived-constant macros IMAGE_SIZE, BANK_DEPTH, ADDR_WIDTH.
- One sub-module, conv_out_addr_gen: ch_cnt/pix_cnt counters, wrap and last-word detection, address computation.
- Bank bookkeeping and the output registers stay in the top module.

Test Plan (IMAGE_WIDTH=2, IMAGE_HEIGHT=2, CHANNEL_NUM_OUT=2, so 8 words/frame, BANK_DEPTH=4*2=8):
- Contiguous words 0..7 -> wr_addr 0,4,1,5,2,6,3,7 with wr_data 0..7; frame_done on the 8th wr_en; frame_bank=0; bank_full=01.
- Second frame, words 8..15 -> wr_addr 8,12,9,13,10,14,11,15; frame_bank=1; bank_full=11.
- Third frame with no release -> wr_en stays 0; overrun=1 one cycle after the first dropped word; counters remain 0.
- bank_release coincident with the first word of a frame -> bank 0 freed; word accepted at wr_addr 0; bank_full=10; overrun stays 1.
- Reset after 3 accepted words -> all outputs 0 the next cycle; the following frame starts at wr_addr 0 with bank_full=00.
- valid_in every other cycle for a full frame -> same address sequence as scenario 1; wr_en gaps match the input gaps; with CONV_OUT_CHECKSUM_EN, frame_checksum = XOR(0..7) = 0.

Source files
------------

// File: rtl/conv_collect_pkg.sv
//------------------------------------------------------------------------------
// Module      : conv_collect_pkg
// Description : Shared bank-state encoding and sizing helper for the conv
//               output frame collector.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package conv_collect_pkg;

    typedef enum logic [1:0] {
        BANK_FREE    = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_t;

    // Counter width that stays legal when a dimension collapses to 1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/conv_out_addr_gen.sv
//------------------------------------------------------------------------------
// Module      : conv_out_addr_gen
// Description : Channel/pixel counters and planar write-address generation.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module conv_out_addr_gen
    import conv_collect_pkg::*;
#(
    parameter int IMAGE_SIZE      = 1024,
    parameter int CHANNEL_NUM_OUT = 128,
    parameter int BANK_DEPTH      = IMAGE_SIZE * CHANNEL_NUM_OUT,
    parameter int ADDR_WIDTH      = $clog2(2 * BANK_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  advance,
    input  logic                  bank,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last_word
);

    localparam int c_CH_W  = cnt_width(CHANNEL_NUM_OUT);
    localparam int c_PIX_W = cnt_width(IMAGE_SIZE);

    logic [c_CH_W-1:0]  r_ch_cnt;
    logic [c_PIX_W-1:0] r_pix_cnt;
    logic               w_ch_wrap;
    logic               w_pix_wrap;

    assign w_ch_wrap  = (r_ch_cnt  == c_CH_W'(CHANNEL_NUM_OUT - 1));
    assign w_pix_wrap = (r_pix_cnt == c_PIX_W'(IMAGE_SIZE - 1));
    assign last_word  = w_ch_wrap && w_pix_wrap;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ch_cnt  <= '0;
            r_pix_cnt <= '0;
        end else if (advance) begin
            if (w_ch_wrap) begin
                r_ch_cnt  <= '0;
                r_pix_cnt <= w_pix_wrap ? '0 : r_pix_cnt + 1'b1;
            end else begin
                r_ch_cnt  <= r_ch_cnt + 1'b1;
            end
        end
    end

    // Planar layout: bank base + channel plane + pixel offset.
    assign addr = (bank ? ADDR_WIDTH'(BANK_DEPTH) : '0)
                + ADDR_WIDTH'(r_ch_cnt) * ADDR_WIDTH'(IMAGE_SIZE)
                + ADDR_WIDTH'(r_pix_cnt);

endmodule

`default_nettype wire

// File: rtl/conv_out_frame_collector.sv
//------------------------------------------------------------------------------
// Module      : conv_out_frame_collector
// Description : De-serialises the channel-interleaved conv output stream into
//               a ping-pong planar frame buffer. Optional macro
//               CONV_OUT_CHECKSUM_EN adds a per-frame XOR checksum output.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module conv_out_frame_collector
    import conv_collect_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int IMAGE_WIDTH     = 32,
    parameter int IMAGE_HEIGHT    = 32,
    parameter int CHANNEL_NUM_OUT = 128,
    parameter int IMAGE_SIZE      = IMAGE_WIDTH * IMAGE_HEIGHT,
    parameter int BANK_DEPTH      = IMAGE_SIZE * CHANNEL_NUM_OUT,
    parameter int ADDR_WIDTH      = $clog2(2 * BANK_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] pxl_in,
    input  logic                  bank_release,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  frame_done,
    output logic                  frame_bank,
    output logic [1:0]            bank_full,
    output logic                  overrun
`ifdef CONV_OUT_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0] frame_checksum
`endif
);

    bank_state_t           r_bank_state [2];
    bank_state_t           w_state_nxt  [2];
    logic                  r_wr_bank;
    logic                  r_rd_bank;
    logic [1:0]            w_full_eff;
    logic                  w_release_ok;
    logic                  w_accept;
    logic                  w_drop;
    logic                  w_last_word;
    logic [ADDR_WIDTH-1:0] w_addr;

    conv_out_addr_gen #(
        .IMAGE_SIZE      (IMAGE_SIZE),
        .CHANNEL_NUM_OUT (CHANNEL_NUM_OUT),
        .BANK_DEPTH      (BANK_DEPTH),
        .ADDR_WIDTH      (ADDR_WIDTH)
    ) u_addr_gen (
        .clk       (clk),
        .reset     (reset),
        .advance   (w_accept),
        .bank      (r_wr_bank),
        .addr      (w_addr),
        .last_word (w_last_word)
    );

    assign w_release_ok = bank_release && (r_bank_state[r_rd_bank] == BANK_FULL);

    // A release of the bank being written frees it in the same cycle.
    for (genvar b = 0; b < 2; b++) begin : g_bank
        assign w_full_eff[b] = (r_bank_state[b] == BANK_FULL)
                            && !(w_release_ok && (r_rd_bank == 1'(b)));
        assign bank_full[b]  = (r_bank_state[b] == BANK_FULL);
    end

    assign w_accept = valid_in && !w_full_eff[r_wr_bank];
    assign w_drop   = valid_in &&  w_full_eff[r_wr_bank];

    always_comb begin
        for (int b = 0; b < 2; b++) begin
            w_state_nxt[b] = r_bank_state[b];
            if (w_release_ok && (r_rd_bank == 1'(b)))
                w_state_nxt[b] = BANK_FREE;
            if (w_accept && (r_wr_bank == 1'(b)))
                w_state_nxt[b] = w_last_word ? BANK_FULL : BANK_FILLING;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < 2; b++) r_bank_state[b] <= BANK_FREE;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
        end else begin
            for (int b = 0; b < 2; b++) r_bank_state[b] <= w_state_nxt[b];
            if (w_accept && w_last_word) r_wr_bank <= ~r_wr_bank;
            if (w_release_ok)            r_rd_bank <= ~r_rd_bank;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
            frame_bank <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            wr_en      <= w_accept;
            frame_done <= w_accept && w_last_word;
            if (w_accept) begin
                wr_addr <= w_addr;
                wr_data <= pxl_in;
            end
            if (w_accept && w_last_word) frame_bank <= r_wr_bank;
            if (w_drop)                  overrun    <= 1'b1;
        end
    end

`ifdef CONV_OUT_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] r_csum_acc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_csum_acc     <= '0;
            frame_checksum <= '0;
        end else if (w_accept) begin
            if (w_last_word) begin
                r_csum_acc     <= '0;
                frame_checksum <= r_csum_acc ^ pxl_in;
            end else begin
                r_csum_acc     <= r_csum_acc ^ pxl_in;
            end
        end
    end
`endif

endmodule

`default_nettype wire
